// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_FLUSH
  } fetch_state_e;

  localparam logic [31:0] FETCH_BASEADDR = 32'h0100_0000;
  localparam int          PC_STEP        = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction-memory port, redirect input and decode handshake.
interface fetch_stage_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              imem_req_o;
  logic [AWIDTH-1:0] imem_addr_o;
  logic              imem_rvalid_i;
  logic [DWIDTH-1:0] imem_rdata_i;
  logic              redirect_i;
  logic [AWIDTH-1:0] redirect_pc_i;
  logic              valid_o;
  logic              ready_i;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] insn_o;
  logic              misalign_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_rvalid_i, imem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output valid_o, pc_o, insn_o, misalign_o,
    input  ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_rvalid_i, imem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  valid_o, pc_o, insn_o, misalign_o,
    output ready_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; zero-latency read of the head entry.
// Simultaneous push and pop are allowed when full; a push into a full FIFO without a pop is dropped.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_q;
  logic [PW:0]      rd_q;
  logic             wr_en;
  logic             rd_en;

  assign count = wr_q - rd_q;
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_q[PW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues in-order imem requests under a credit limit, buffers {pc,insn} for decode.
// Response visible one cycle after rvalid; ready_i low stalls issue via credits. Option: FETCH_MISALIGN_CHK_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(FETCH_BASEADDR),
  parameter int                DEPTH    = 2
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);
  localparam int                CW   = $clog2(DEPTH) + 1;
  localparam logic [AWIDTH-1:0] STEP = AWIDTH'(PC_STEP);

  fetch_state_e      state_q, state_d;
  logic [AWIDTH-1:0] pc_q, resp_pc_q, redir_pc;
  logic [CW-1:0]     outst_q, drop_q, drop_d, surv;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [AWIDTH+DWIDTH-1:0] fifo_rdata;
  logic              rsp, issue, push, pop, halt, credit_ok;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;
  assign redir_pc = bus.redirect_pc_i;
  assign halt     = misalign_q;

  // A misaligned target stops fetching for good; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)                                             misalign_q <= 1'b0;
    else if (bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00)) misalign_q <= 1'b1;
  end
  assign bus.misalign_o = misalign_q;
`else
  assign redir_pc       = bus.redirect_pc_i & ~AWIDTH'(3);
  assign halt           = 1'b0;
  assign bus.misalign_o = 1'b0;
`endif

  assign rsp       = bus.imem_rvalid_i && (outst_q != '0);
  assign surv      = outst_q - CW'(rsp);
  assign credit_ok = !fifo_full && (({1'b0, outst_q} + {1'b0, fifo_count}) < (CW+1)'(DEPTH));
  assign pop       = !fifo_empty && bus.ready_i && !bus.redirect_i;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    issue   = 1'b0;
    push    = 1'b0;
    case (state_q)
      FETCH_IDLE: state_d = FETCH_RUN;
      FETCH_RUN: begin
        if (!bus.redirect_i) begin
          issue = !halt && credit_ok;
          push  = rsp;
        end
      end
      FETCH_FLUSH: begin
        if (!bus.redirect_i && rsp) begin
          drop_d = drop_q - CW'(1);
          if (drop_q == CW'(1)) state_d = FETCH_RUN;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
    // Anything still in flight at a redirect belongs to the old path and must be dropped.
    if (bus.redirect_i) begin
      drop_d = surv;
      if (state_q != FETCH_IDLE) state_d = (surv != '0) ? FETCH_FLUSH : FETCH_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH_IDLE;
      pc_q      <= BASEADDR;
      resp_pc_q <= BASEADDR;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      outst_q <= outst_q + CW'(issue) - CW'(rsp);
      if (bus.redirect_i) begin
        pc_q      <= redir_pc;
        resp_pc_q <= redir_pc;
      end else begin
        if (issue) pc_q      <= pc_q + STEP;
        if (push)  resp_pc_q <= resp_pc_q + STEP;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (AWIDTH + DWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_i),
    .wdata ({resp_pc_q, bus.imem_rdata_i}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.imem_req_o  = issue;
  assign bus.imem_addr_o = pc_q;
  assign bus.valid_o     = !fifo_empty;
  assign bus.pc_o        = fifo_empty ? '0 : fifo_rdata[AWIDTH+DWIDTH-1:DWIDTH];
  assign bus.insn_o      = fifo_empty ? '0 : fifo_rdata[DWIDTH-1:0];
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model plus an expected-PC-stream reference.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h0100_0000;

  logic clk = 1'b0;
  logic reset;

  fetch_stage_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  fetch_stage #(
    .DWIDTH   (DW),
    .AWIDTH   (AW),
    .BASEADDR (BASE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } rsp_t;

  rsp_t        mq[$];
  int          total = 0, bad = 0;
  int          cyc = 0, last_due = 0, lat_min = 1, lat_max = 1, n_acc = 0;
  logic [31:0] exp_issue, exp_out;
  bit          halted, mis_exp;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset             = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.ready_i       = 1'b0;
    repeat (2) @(posedge clk);
    mq.delete();
    exp_issue = BASE;
    exp_out   = BASE;
    halted    = 0;
    mis_exp   = 0;
    last_due  = 0;
  endtask

  // Apply this cycle's inputs (including any due memory response), then let outputs settle.
  task automatic drive(input logic rd, input logic [31:0] tgt, input logic rdy);
    @(negedge clk);
    reset             = 1'b0;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = tgt;
    bus.ready_i       = rdy;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = word_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = $urandom;
    end
    #1;
  endtask

  // Compare outputs against the expected fetch/decode streams, then advance one clock.
  task automatic commit();
    logic [31:0] t;
    int          d;
    check("misalign", bus.misalign_o, mis_exp);
    check("halt_noreq", bus.imem_req_o && (halted || bus.redirect_i), 0);
    if (bus.imem_req_o) begin
      check("req_addr", bus.imem_addr_o, exp_issue);
      d = cyc + $urandom_range(lat_min, lat_max);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{due: d, addr: bus.imem_addr_o});
      exp_issue += 32'd4;
      check("credit", mq.size() <= DEPTH, 1);
    end
    if (bus.valid_o && bus.ready_i && !bus.redirect_i) begin
      check("out_pc", bus.pc_o, exp_out);
      check("out_insn", bus.insn_o, word_of(exp_out));
      exp_out += 32'd4;
      n_acc++;
    end else if (!bus.valid_o) begin
      check("empty_zero", {bus.pc_o, bus.insn_o}, 0);
    end
    if (bus.redirect_i) begin
`ifdef FETCH_MISALIGN_CHK_EN
      t = bus.redirect_pc_i;
      if (t[1:0] != 2'b00) begin
        halted  = 1;
        mis_exp = 1;
      end
`else
      t = {bus.redirect_pc_i[31:2], 2'b00};
`endif
      exp_issue = t;
      exp_out   = t;
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic cycle(input logic rd, input logic [31:0] tgt, input logic rdy);
    drive(rd, tgt, rdy);
    commit();
  endtask

  // Reset, then stall decode until the FIFO is full and nothing is outstanding.
  task automatic fill();
    do_reset();
    lat_min = 1;
    lat_max = 1;
    repeat (6) cycle(1'b0, '0, 1'b0);
  endtask

  initial begin
    int          n, a, r;
    bit          seen;
    logic [31:0] tgt;

    reset             = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.ready_i       = 1'b0;

    // Reset values, then first fetches with latency 1
    lat_min = 1;
    lat_max = 1;
    do_reset();
    drive(1'b0, '0, 1'b1);
    check("rst_req", bus.imem_req_o, 0);
    check("rst_addr", bus.imem_addr_o, BASE);
    check("rst_valid", bus.valid_o, 0);
    check("rst_pc", bus.pc_o, 0);
    check("rst_insn", bus.insn_o, 0);
    check("rst_misalign", bus.misalign_o, 0);
    commit();
    drive(1'b0, '0, 1'b1);
    check("t1_req0", {bus.imem_req_o, bus.imem_addr_o}, {1'b1, BASE});
    commit();
    drive(1'b0, '0, 1'b1);
    check("t1_req1", {bus.imem_req_o, bus.imem_addr_o}, {1'b1, BASE + 32'd4});
    commit();
    drive(1'b0, '0, 1'b1);
    check("t1_valid", {bus.valid_o, bus.pc_o}, {1'b1, BASE});
    commit();
    repeat (10) cycle(1'b0, '0, 1'b1);

    // Decode stalled: only DEPTH fetches, then an in-order drain
    do_reset();
    n = 0;
    repeat (10) begin
      drive(1'b0, '0, 1'b0);
      n += int'(bus.imem_req_o);
      commit();
    end
    check("t2_nreq", n, DEPTH);
    a = n_acc;
    drive(1'b0, '0, 1'b1);
    check("t2_full_valid", bus.valid_o, 1);
    commit();
    repeat (10) cycle(1'b0, '0, 1'b1);
    check("t2_drain", (n_acc - a) >= 4, 1);

    // Redirect with two fetches in flight: both dropped
    do_reset();
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (mq.size() == 2) break;
    end
    check("t3_two_out", mq.size(), 2);
    cycle(1'b1, 32'h0100_0100, 1'b1);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      drive(1'b0, '0, 1'b1);
      if (bus.valid_o) begin
        check("t3_first_pc", bus.pc_o, 32'h0100_0100);
        seen = 1;
      end
      commit();
    end
    check("t3_seen", seen, 1);

    // PC wraps at the top of the address space
    fill();
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    drive(1'b0, '0, 1'b1);
    check("t4_req_tgt", {bus.imem_req_o, bus.imem_addr_o}, {1'b1, 32'hFFFF_FFFC});
    commit();
    drive(1'b0, '0, 1'b1);
    check("t4_wrap", {bus.imem_req_o, bus.imem_addr_o}, {1'b1, 32'h0000_0000});
    commit();
    repeat (8) cycle(1'b0, '0, 1'b1);

    // Misaligned redirect
    fill();
    cycle(1'b1, 32'h0100_0102, 1'b1);
`ifdef FETCH_MISALIGN_CHK_EN
    n = 0;
    drive(1'b0, '0, 1'b1);
    check("t5_misalign", bus.misalign_o, 1);
    n += int'(bus.imem_req_o);
    commit();
    repeat (9) begin
      drive(1'b0, '0, 1'b1);
      n += int'(bus.imem_req_o);
      commit();
    end
    check("t5_noreq", n, 0);
`else
    drive(1'b0, '0, 1'b1);
    check("t5_resume", {bus.imem_req_o, bus.imem_addr_o}, {1'b1, 32'h0100_0100});
    check("t5_misalign", bus.misalign_o, 0);
    commit();
    repeat (6) cycle(1'b0, '0, 1'b1);
`endif

    // Reset mid-operation
    fill();
    drive(1'b0, '0, 1'b0);
    check("t6_full", bus.valid_o, 1);
    commit();
    do_reset();
    drive(1'b0, '0, 1'b1);
    check("t6_valid", bus.valid_o, 0);
    check("t6_addr", bus.imem_addr_o, BASE);
    commit();

    // Random traffic: variable latency, random stalls and redirects
    do_reset();
    lat_min = 1;
    lat_max = 3;
    a = n_acc;
    repeat (3000) begin
      r = $urandom_range(0, 9);
      if (r == 0) tgt = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      else        tgt = BASE + (32'($urandom_range(0, 1023)) << 2);
`ifndef FETCH_MISALIGN_CHK_EN
      tgt = tgt | 32'($urandom_range(0, 3));
`endif
      cycle($urandom_range(0, 99) < 3, tgt, $urandom_range(0, 99) < 70);
    end
    check("rand_progress", (n_acc - a) > 200, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
